// File: rtl/taus_sched_pkg.sv
// Shared types and constants for the Tausworthe URNG scheduler.
package taus_sched_pkg;

    localparam int unsigned URNG_W         = 64;
    localparam int unsigned DEF_NREQ       = 4;
    localparam int unsigned DEF_WARMUP_CYC = 4;
    localparam int unsigned DEF_CNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

endpackage

// File: rtl/taus_urng_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // ptr + off folded back into 0..N-1 (ptr is always < N, off < N)
    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int unsigned off);
        int unsigned k;
        k = 32'(p) + off;
        if (k >= N) k = k - N;
        return IW'(k);
    endfunction

    // Scan from ptr upward; the first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[rot_idx(ptr, i)]) begin
                any                  = 1'b1;
                gnt_idx              = rot_idx(ptr, i);
                gnt[rot_idx(ptr, i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/taus_urng_sched.sv
// Start-up sequencer and round-robin distributor for one shared 64-bit Tausworthe URNG.
module taus_urng_sched
    import taus_sched_pkg::*;
#(
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned WARMUP_CYC = DEF_WARMUP_CYC,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic              urng_en,
    input  logic [URNG_W-1:0] urng_data,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   rn_valid,
    output logic [URNG_W-1:0] rn_data,
    output logic              ready,
    output logic [CNT_W-1:0]  words_served
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WC_W  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

    state_t            state;
    state_t            state_nx;
    logic [WC_W-1:0]   wcnt;
    logic [PTR_W-1:0]  ptr;
    logic [NREQ-1:0]   gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic              any;
    logic              fire_c;
    logic              restart_c;
    logic              warm_keep_c;
    logic [PTR_W-1:0]  ptr_nx_c;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: stop always wins, start only matters in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !stop) state_nx = WARMUP;
            WARMUP:  if (stop) state_nx = IDLE;
                     else if (wcnt == WC_W'(WARMUP_CYC - 1)) state_nx = RUN;
            RUN:     if (stop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Per-cycle control decode; a stop in RUN cancels that cycle's grant
    always_comb begin
        fire_c      = (state == RUN) && !stop && any;
        restart_c   = (state == IDLE) && (state_nx == WARMUP);
        warm_keep_c = (state == WARMUP) && (state_nx == WARMUP);
        ptr_nx_c    = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    // Output, pointer, warm-up and served-word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            urng_en      <= 1'b0;
            ready        <= 1'b0;
            rn_valid     <= '0;
            rn_data      <= '0;
            words_served <= '0;
            ptr          <= '0;
            wcnt         <= '0;
        end else begin
            urng_en  <= (state_nx != IDLE);
            ready    <= (state_nx == RUN);
            rn_valid <= fire_c ? gnt : '0;
            wcnt     <= warm_keep_c ? wcnt + WC_W'(1) : '0;
            if (fire_c) rn_data <= urng_data;
            if (restart_c) begin
                ptr          <= '0;
                words_served <= '0;
            end else if (fire_c) begin
                ptr <= ptr_nx_c;
                if (words_served != '1) words_served <= words_served + CNT_W'(1);
            end
        end
    end

endmodule
